// File: rtl/keypad_if.sv
// Command and row/column bus between the keypad row scanner and the keypad model.
interface keypad_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] row;
  logic [3:0] col;
  logic       busy;
  logic       done;

  modport master (output key_valid, key_code, row, input key_ready, col, busy, done);
  modport slave  (input key_valid, key_code, row, output key_ready, col, busy, done);
endinterface

// File: rtl/keypad_matrix_model.sv
// 4x4 keypad emulator: presses one key per command, bounces the contact on make and
// break, and answers the scanner's row drive on col.
module keypad_matrix_model #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 2000,
  parameter int unsigned GAP_CYCLES    = 500,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input logic     clk,
  input logic     rst,
  keypad_if.slave kp
);

  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int unsigned CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] B_LOAD = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] H_LOAD = CW'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);
  localparam logic [CW-1:0] G_LOAD = CW'((GAP_CYCLES    > 0) ? GAP_CYCLES    - 1 : 0);
  localparam logic [7:0]    TAPS   = 8'hB8;

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic [7:0]    lfsr_q, lfsr_d, lfsr_step;
  logic          contact_q, contact_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

  // Each state lasts cnt-load + 1 cycles; cnt reloads on every transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    lfsr_d    = lfsr_q;
    contact_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (kp.key_valid && ready_q) begin
          code_d = kp.key_code;
          if (BOUNCE_CYCLES == 0) begin
            state_d = HOLD;
            cnt_d   = H_LOAD;
          end else begin
            state_d = BOUNCE_IN;
            cnt_d   = B_LOAD;
          end
        end
      end
      BOUNCE_IN: begin
        lfsr_d    = lfsr_step;
        contact_d = (cnt_q == '0) ? 1'b1 : lfsr_q[0];
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = H_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        contact_d = 1'b1;
        if (cnt_q == '0) begin
          if (BOUNCE_CYCLES == 0) begin
            state_d = GAP;
            cnt_d   = G_LOAD;
          end else begin
            state_d = BOUNCE_OUT;
            cnt_d   = B_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BOUNCE_OUT: begin
        lfsr_d    = lfsr_step;
        contact_d = (cnt_q == '0) ? 1'b0 : lfsr_q[0];
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = G_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= 4'h0;
      lfsr_q    <= LFSR_SEED;
      contact_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      lfsr_q    <= lfsr_d;
      contact_q <= contact_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Passive matrix: the closed contact shorts the selected row onto the selected column.
  assign kp.col       = (contact_q && kp.row[code_q[3:2]]) ? (4'b0001 << code_q[1:0]) : 4'b0000;
  assign kp.key_ready = ready_q;
  assign kp.busy      = busy_q;
  assign kp.done      = done_q;

endmodule
